// File: rtl/demux_router.sv
// demux_router: routes one input stream into four single-entry buffers, each with its own valid/ready drain.
// Ports: clk, rst, input_data/signal/in_valid/in_ready in; q0..q3/out_valid/out_ready out; err_clr/err; cnt0..cnt3 with DEMUX_ROUTER_COUNT_EN.
module demux_router #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input_data,
  input  logic [SEL_W-1:0] signal,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  input  logic             err_clr,
  output logic             err
`ifdef DEMUX_ROUTER_COUNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [15:0]      cnt3
`endif
);

  logic [WIDTH-1:0] q_r [4];
  logic [3:0]       vld_r;
  logic             err_r;
  logic [1:0]       sel;
  logic             legal;
  logic             acc;
  logic [3:0]       fill;

  assign sel   = signal[1:0];
  assign legal = (signal >> 2) == '0;

  // illegal selects are always swallowed
  assign in_ready = !legal || !vld_r[sel] || out_ready[sel];
  assign acc      = in_valid && in_ready;

  always_comb begin
    fill = '0;
    if (acc && legal) begin
      unique case (1'b1)
        sel == 2'd0: fill = 4'b0001;
        sel == 2'd1: fill = 4'b0010;
        sel == 2'd2: fill = 4'b0100;
        sel == 2'd3: fill = 4'b1000;
        default:     fill = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) q_r[i] <= '0;
      vld_r <= '0;
      err_r <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (fill[i]) q_r[i] <= input_data;
      vld_r <= fill | (vld_r & ~out_ready);
      err_r <= (acc && !legal) || (err_r && !err_clr);
    end
  end

  assign q0        = q_r[0];
  assign q1        = q_r[1];
  assign q2        = q_r[2];
  assign q3        = q_r[3];
  assign out_valid = vld_r;
  assign err       = err_r;

`ifdef DEMUX_ROUTER_COUNT_EN
  logic [15:0] cnt_r [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        cnt_r[i] <= cnt_r[i] + 16'(fill[i]);
    end
  end

  assign cnt0 = cnt_r[0];
  assign cnt1 = cnt_r[1];
  assign cnt2 = cnt_r[2];
  assign cnt3 = cnt_r[3];
`endif

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: vector table, async-reset sequence and randomized model check for demux_router.
// Counter checks are built only with DEMUX_ROUTER_COUNT_EN.
module tb_demux_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_data;
  logic [3:0]  signal;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] q0, q1, q2, q3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_clr;
  logic        err;
`ifdef DEMUX_ROUTER_COUNT_EN
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

  always #5 clk = ~clk;

  demux_router dut (
    .clk(clk), .rst(rst),
    .input_data(input_data), .signal(signal),
    .in_valid(in_valid), .in_ready(in_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_clr(err_clr), .err(err)
`ifdef DEMUX_ROUTER_COUNT_EN
    , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
  );

  logic [31:0] qs [4];
  assign qs[0] = q0;
  assign qs[1] = q1;
  assign qs[2] = q2;
  assign qs[3] = q3;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [3:0]  sig;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        clr;
    logic        e_rdy;
    logic [3:0]  e_vld;
    logic        e_err;
    int          ch;
    logic [31:0] e_q;
  } vec_t;

  vec_t vt [12];

  // reference model: buffers as plain arrays, updated once per edge
  logic [31:0] mq [4];
  logic [3:0]  mv;
  logic        merr;
  int unsigned mc [4];

  function automatic logic m_ready();
    if (signal > 4'd3) return 1'b1;
    return !mv[signal] || out_ready[signal];
  endfunction

  task automatic m_edge();
    logic a;
    a = in_valid && m_ready();
    for (int i = 0; i < 4; i++)
      if (mv[i] && out_ready[i]) mv[i] = 1'b0;
    if (a && signal <= 4'd3) begin
      mq[signal] = input_data;
      mv[signal] = 1'b1;
      mc[signal] = (mc[signal] + 1) % 65536;
    end
    if (a && signal > 4'd3) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = '0;
      mc[i] = 0;
    end
    mv   = '0;
    merr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; signal = '0; input_data = '0;
    out_ready = '0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
  endtask

  task automatic rand_cycle();
    #1;
    chk("rnd in_ready", 32'(in_ready), 32'(m_ready()));
    m_edge();
    @(posedge clk); #1;
    chk("rnd out_valid", 32'(out_valid), 32'(mv));
    chk("rnd err", 32'(err), 32'(merr));
    for (int i = 0; i < 4; i++)
      if (qs[i] !== mq[i]) chk($sformatf("rnd q%0d", i), qs[i], mq[i]);
`ifdef DEMUX_ROUTER_COUNT_EN
    if (cnt0 !== 16'(mc[0])) chk("rnd cnt0", 32'(cnt0), mc[0]);
    if (cnt3 !== 16'(mc[3])) chk("rnd cnt3", 32'(cnt3), mc[3]);
`endif
  endtask

  initial begin
    //           iv sig  data          ordy    clr rdy vld     err ch q
    vt[0]  = '{1, 4'h2, 32'hDEADBEEF, 4'b0000, 0, 1, 4'b0100, 0, 2, 32'hDEADBEEF};
    vt[1]  = '{1, 4'h2, 32'h12345678, 4'b0000, 0, 0, 4'b0100, 0, 2, 32'hDEADBEEF};
    vt[2]  = '{1, 4'h2, 32'h12345678, 4'b0100, 0, 1, 4'b0100, 0, 2, 32'h12345678};
    vt[3]  = '{1, 4'h0, 32'h00000011, 4'b0000, 0, 1, 4'b0101, 0, 0, 32'h00000011};
    vt[4]  = '{1, 4'h9, 32'hFFFFFFFF, 4'b0000, 0, 1, 4'b0101, 1, 2, 32'h12345678};
    vt[5]  = '{0, 4'h1, 32'h0,        4'b0000, 1, 1, 4'b0101, 0, 0, 32'h00000011};
    vt[6]  = '{1, 4'hF, 32'h0,        4'b0000, 1, 1, 4'b0101, 1, 1, 32'h0};
    vt[7]  = '{1, 4'h1, 32'h0000AAAA, 4'b0001, 1, 1, 4'b0110, 0, 0, 32'h00000011};
    vt[8]  = '{1, 4'h1, 32'h0000BBBB, 4'b0010, 0, 1, 4'b0110, 0, 1, 32'h0000BBBB};
    vt[9]  = '{1, 4'h3, 32'h00003333, 4'b0000, 0, 1, 4'b1110, 0, 3, 32'h00003333};
    vt[10] = '{1, 4'h0, 32'h00000044, 4'b0000, 0, 1, 4'b1111, 0, 0, 32'h00000044};
    vt[11] = '{1, 4'h7, 32'h77777777, 4'b0000, 0, 1, 4'b1111, 1, 3, 32'h00003333};

    do_reset();
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset q%0d", i), qs[i], 32'h0);

    foreach (vt[k]) begin
      in_valid = vt[k].iv; signal = vt[k].sig; input_data = vt[k].d;
      out_ready = vt[k].ordy; err_clr = vt[k].clr;
      #1;
      chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(vt[k].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vt[k].e_vld));
      chk($sformatf("v%0d err", k), 32'(err), 32'(vt[k].e_err));
      chk($sformatf("v%0d q%0d", k, vt[k].ch), qs[vt[k].ch], vt[k].e_q);
      if (k == 0) begin
        chk("v0 q0", q0, 32'h0);
        chk("v0 q1", q1, 32'h0);
        chk("v0 q3", q3, 32'h0);
      end
    end

    // async reset between edges, everything full and err set
    in_valid = 1'b0; out_ready = '0; err_clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async out_valid", 32'(out_valid), 32'h0);
    chk("async err", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("async q%0d", i), qs[i], 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();

    for (int n = 0; n < 600; n++) begin
      in_valid   = $urandom_range(0, 3) != 0;
      signal     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(4, 15))
                                               : 4'($urandom_range(0, 3));
      input_data = $urandom;
      out_ready  = 4'($urandom);
      err_clr    = $urandom_range(0, 7) == 0;
      rand_cycle();
    end

`ifdef DEMUX_ROUTER_COUNT_EN
    begin
      int stalls;
      stalls = 0;
      do_reset();
      in_valid = 1'b1; signal = 4'h3; out_ready = 4'b1000;
      for (int n = 0; n < 65537; n++) begin
        input_data = 32'(n);
        #1;
        if (!in_ready) stalls++;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("stream stalls", 32'(stalls), 32'h0);
      chk("stream cnt3", 32'(cnt3), 32'h1);
      chk("stream cnt0", 32'(cnt0), 32'h0);
      chk("stream cnt1", 32'(cnt1), 32'h0);
      chk("stream cnt2", 32'(cnt2), 32'h0);
      chk("stream q3", q3, 32'h00010000);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_router.md
Name: demux_router

Overview:
- Sequential 1-to-4 demultiplexer; the inverse of the 4:1 data mux.
- Takes one 32-bit input stream and a 4-bit select `signal`, and routes each accepted word into one of four single-entry output buffers (q0..q3).
- Each output has its own valid/ready handshake.
- Used in the datapath wherever one producer (e.g. ALU result or memory read) feeds several consumers that drain at different times.

Parameters:
- WIDTH, 32, data width of input_data and q0..q3.
- SEL_W, 4, width of signal; only encodings 0..3 are legal.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- input_data  input  WIDTH  word to route.
- signal  input  SEL_W  destination select: 0->q0, 1->q1, 2->q2, 3->q3; 4..15 illegal.
- in_valid  input  1  input_data/signal valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- q0, q1, q2, q3  output  WIDTH  buffered output data per channel.
- out_valid  output  4  bit i set when qi holds an undelivered word.
- out_ready  input  4  bit i: consumer i takes qi this cycle.
- err_clr  input  1  synchronous clear of err.
- err  output  1  sticky flag: an illegal signal was accepted.

Behaviour:
- Reset (async, rst=1): q0..q3=0, out_valid=4'b0000, err=0. in_ready is combinational and therefore reads 1 while in_valid=0.
- Drain: channel i drains on a posedge when out_valid[i] && out_ready[i]; out_valid[i] then clears unless refilled in the same cycle.
- Legal select: for signal=s in 0..3, in_ready = !out_valid[s] || out_ready[s]. The buffer is either empty or draining this cycle, so one word per cycle per channel is sustained.
- Acceptance: occurs when in_valid && in_ready. On that posedge, q[s] <= input_data and out_valid[s] <= 1.
- Latency: word accepted at edge N is visible on q[s] with out_valid[s]=1 after edge N, i.e. one cycle.
- Illegal select: for signal in 4..15, in_ready=1 and the word is consumed and discarded. No q or out_valid change; err <= 1 on that edge.
- err handling: err_clr=1 clears err on the next edge. If err_clr and an illegal accept occur on the same edge, err=1 (set wins).
- Simultaneous events: fill of channel s and drains of any channels (including s) on the same edge are all honoured. Drain-and-refill of s leaves out_valid[s]=1 with the new data.
- Isolation: a full, stalled channel blocks only inputs addressed to it. in_ready reflects the current signal; there is no head-of-line state inside the block.
- Stability: q[i] holds its value while out_valid[i]=1 and out_ready[i]=0. q[i] keeps its last data after draining; it is not zeroed.
- in_valid=0: no state change except drains and err_clr.
- Reset mid-operation: all buffered words are lost, out_valid returns to 0 immediately (asynchronous), and no partial transfer completes.

Optional Feature:
- Macro DEMUX_ROUTER_COUNT_EN.
- When defined: adds output ports cnt0..cnt3, 16 bits each. cnt_i increments on each accepted legal word routed to channel i, wraps 16'hFFFF->0, resets to 0, and is unaffected by err_clr or drains.
- When undefined: the ports and counters are absent and the remaining behaviour is identical.

Test Plan:
- Single route: after reset, in_valid=1, signal=2, input_data=32'hDEADBEEF, out_ready=0. Required: in_ready=1; after the edge q2=DEADBEEF, out_valid=4'b0100; q0, q1, q3 stay 0.
- Backpressure: channel 2 full, out_ready=0, signal=2, data=32'h12345678. Required: in_ready=0 and q2 stays DEADBEEF. Next cycle out_ready=4'b0100: in_ready=1, and after the edge q2=12345678 with out_valid[2] still 1.
- Isolation: channel 2 full and stalled, signal=0, data=32'h00000011. Required: in_ready=1; after the edge q0=11, out_valid=4'b0101.
- Illegal select: signal=4'h9, data=32'hFFFFFFFF. Required: in_ready=1, after the edge err=1 and out_valid/q unchanged. Then err_clr=1 with no illegal input clears err to 0. err_clr=1 together with signal=4'hF gives err=1.
- Async reset mid-stream: out_valid=4'b1111, rst pulsed between edges. Required: out_valid=0, q0..q3=0, err=0 immediately, before the next posedge.
- Counters (DEMUX_ROUTER_COUNT_EN): stream 65537 words to channel 3 with out_ready[3]=1 continuously. Required: cnt3=1 (wrapped); cnt0..cnt2=0; one word per cycle throughput, in_ready never deasserts.
